// File: rtl/bsg_cache_dma_arbiter.sv
// Arbitrates per-cache DMA packets onto one memory-side DMA engine and steers read/write
// data by requester-id tag FIFOs. Define BSG_CACHE_DMA_ARB_RR_EN for round-robin grant.
module bsg_cache_dma_arbiter #(
  parameter int num_req_p             = 4,
  parameter int addr_width_p          = 32,
  parameter int data_width_p          = 32,
  parameter int block_size_in_words_p = 8,
  parameter int tag_els_p             = 4
) (
  input  logic                                    clk_i,
  input  logic                                    reset_i,

  input  logic [num_req_p*(addr_width_p+1)-1:0]   dma_pkt_i,
  input  logic [num_req_p-1:0]                    dma_pkt_v_i,
  output logic [num_req_p-1:0]                    dma_pkt_yumi_o,

  output logic [data_width_p-1:0]                 dma_data_o,
  output logic [num_req_p-1:0]                    dma_data_v_o,
  input  logic [num_req_p-1:0]                    dma_data_ready_i,

  input  logic [num_req_p*data_width_p-1:0]       dma_data_i,
  input  logic [num_req_p-1:0]                    dma_data_v_i,
  output logic [num_req_p-1:0]                    dma_data_yumi_o,

  output logic [addr_width_p:0]                   mem_pkt_o,
  output logic                                    mem_pkt_v_o,
  input  logic                                    mem_pkt_yumi_i,

  input  logic [data_width_p-1:0]                 mem_data_i,
  input  logic                                    mem_data_v_i,
  output logic                                    mem_data_ready_o,

  output logic [data_width_p-1:0]                 mem_data_o,
  output logic                                    mem_data_v_o,
  input  logic                                    mem_data_yumi_i
);

  localparam int pkt_w_lp  = addr_width_p + 1;
  localparam int id_w_lp   = $clog2(num_req_p);
  localparam int ptr_w_lp  = (tag_els_p > 1) ? $clog2(tag_els_p) : 1;
  localparam int cnt_w_lp  = $clog2(tag_els_p + 1);
  localparam int word_w_lp = $clog2(block_size_in_words_p);

  // Channel index 0 is the read direction, 1 is the write direction.
  logic [1:0]              push, pop, full, empty, beat;
  logic [id_w_lp-1:0]      head [2];
  logic [id_w_lp-1:0]      grant_id;
  logic                    grant_wnr, accept;

  logic [pkt_w_lp-1:0]     pkts  [num_req_p];
  logic [data_width_p-1:0] wdata [num_req_p];
  logic [num_req_p-1:0]    wnr, eligible;

  for (genvar gi = 0; gi < num_req_p; gi++) begin : g_req
    assign pkts[gi]     = dma_pkt_i[gi*pkt_w_lp +: pkt_w_lp];
    assign wdata[gi]    = dma_data_i[gi*data_width_p +: data_width_p];
    assign wnr[gi]      = pkts[gi][addr_width_p];
    assign eligible[gi] = dma_pkt_v_i[gi] & ~full[wnr[gi]];
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    logic [id_w_lp-1:0]   tags_q [tag_els_p];
    logic [id_w_lp-1:0]   tags_d [tag_els_p];
    logic [ptr_w_lp-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [cnt_w_lp-1:0]  cnt_q, cnt_d;
    logic [word_w_lp-1:0] word_q, word_d;
    logic                 last_word;

    assign last_word = word_q == word_w_lp'(block_size_in_words_p - 1);
    assign pop[gi]   = beat[gi] & last_word;
    assign full[gi]  = cnt_q == cnt_w_lp'(tag_els_p);
    assign empty[gi] = cnt_q == '0;
    assign head[gi]  = tags_q[rptr_q];

    always_comb begin
      tags_d = tags_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      word_d = word_q;
      if (push[gi]) begin
        tags_d[wptr_q] = grant_id;
        wptr_d = (wptr_q == ptr_w_lp'(tag_els_p - 1)) ? '0 : wptr_q + ptr_w_lp'(1);
      end
      if (pop[gi])
        rptr_d = (rptr_q == ptr_w_lp'(tag_els_p - 1)) ? '0 : rptr_q + ptr_w_lp'(1);
      case ({push[gi], pop[gi]})
        2'b10:   cnt_d = cnt_q + cnt_w_lp'(1);
        2'b01:   cnt_d = cnt_q - cnt_w_lp'(1);
        default: cnt_d = cnt_q;
      endcase
      if (beat[gi])
        word_d = last_word ? '0 : word_q + word_w_lp'(1);
    end

    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        tags_q <= '{default: '0};
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
        word_q <= '0;
      end else begin
        tags_q <= tags_d;
        wptr_q <= wptr_d;
        rptr_q <= rptr_d;
        cnt_q  <= cnt_d;
        word_q <= word_d;
      end
    end
  end

`ifdef BSG_CACHE_DMA_ARB_RR_EN
  logic [id_w_lp-1:0] rr_q, rr_d;

  // Scan downward so the requester nearest the pointer is the last (winning) assignment.
  always_comb begin
    grant_id = '0;
    for (int k = num_req_p - 1; k >= 0; k--) begin
      if (eligible[(int'(rr_q) + k) % num_req_p])
        grant_id = id_w_lp'((int'(rr_q) + k) % num_req_p);
    end
    rr_d = rr_q;
    if (accept)
      rr_d = (int'(grant_id) == num_req_p - 1) ? '0 : grant_id + id_w_lp'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) rr_q <= '0;
    else         rr_q <= rr_d;
  end
`else
  always_comb begin
    grant_id = '0;
    for (int k = num_req_p - 1; k >= 0; k--) begin
      if (eligible[k]) grant_id = id_w_lp'(k);
    end
  end
`endif

  assign mem_pkt_v_o = (|eligible) & ~reset_i;
  assign mem_pkt_o   = pkts[grant_id];
  assign grant_wnr   = wnr[grant_id];
  assign accept      = mem_pkt_v_o & mem_pkt_yumi_i;
  assign push        = {accept & grant_wnr, accept & ~grant_wnr};

  always_comb begin
    dma_pkt_yumi_o = '0;
    if (accept) dma_pkt_yumi_o[grant_id] = 1'b1;
  end

  always_comb begin
    dma_data_v_o     = '0;
    dma_data_o       = '0;
    mem_data_ready_o = 1'b0;
    mem_data_v_o     = 1'b0;
    mem_data_o       = '0;
    dma_data_yumi_o  = '0;
    if (!empty[0] && !reset_i) begin
      dma_data_v_o[head[0]] = mem_data_v_i;
      mem_data_ready_o      = dma_data_ready_i[head[0]];
      dma_data_o            = mem_data_i;
    end
    if (!empty[1] && !reset_i) begin
      mem_data_v_o             = dma_data_v_i[head[1]];
      mem_data_o               = wdata[head[1]];
      dma_data_yumi_o[head[1]] = mem_data_yumi_i;
    end
  end

  assign beat[0] = mem_data_v_i & mem_data_ready_o;
  assign beat[1] = mem_data_v_o & mem_data_yumi_i;

endmodule

// File: doc/bsg_cache_dma_arbiter.md
BSG_CACHE_DMA_ARBITER -- requirements
Module: bsg_cache_dma_arbiter

Interface
REQ-001 num_req_p, no default, number of requesting caches (2..16).
REQ-002 addr_width_p, no default, DMA packet address width.
REQ-003 data_width_p, no default, DMA data word width.
REQ-004 block_size_in_words_p, no default, words per DMA transfer (power of 2, >=2).
REQ-005 tag_els_p, default 4, outstanding transactions tracked per direction.
REQ-006 clk_i  in  1  single clock; reset is synchronous and active-high.
REQ-007 reset_i  in  1  synchronous active-high reset.
REQ-008 dma_pkt_i  in  num_req_p*pkt_w  per-requester DMA packet {write_not_read, addr}; pkt_w=addr_width_p+1.
REQ-009 dma_pkt_v_i  in  num_req_p  per-requester packet valid.
REQ-010 dma_pkt_yumi_o  out  num_req_p  per-requester packet accept.
REQ-011 dma_data_o  out  data_width_p  read data to requesters (shared bus).
REQ-012 dma_data_v_o  out  num_req_p  read data valid, one-hot.
REQ-013 dma_data_ready_i  in  num_req_p  requester ready for read data.
REQ-014 dma_data_i  in  num_req_p*data_width_p  per-requester write data.
REQ-015 dma_data_v_i  in  num_req_p  write data valid.
REQ-016 dma_data_yumi_o  out  num_req_p  write data accept.
REQ-017 mem_pkt_o / mem_pkt_v_o / mem_pkt_yumi_i  out/out/in  pkt_w/1/1  packet to memory-side DMA engine.
REQ-018 mem_data_i / mem_data_v_i / mem_data_ready_o  in/in/out  data_width_p/1/1  read data from memory.
REQ-019 mem_data_o / mem_data_v_o / mem_data_yumi_i  out/out/in  data_width_p/1/1  write data to memory.

Function
REQ-020 Arbiter SHALL select one valid requester per cycle; mem_pkt_o = selected packet, mem_pkt_v_o = any eligible valid.
REQ-021 Requester eligible only if target tag FIFO (read or write, per write_not_read) not full.
REQ-022 dma_pkt_yumi_o[g] SHALL assert only in cycle of mem_pkt_yumi_i for granted g; combinational, zero latency.
REQ-023 On accept, requester id SHALL be pushed to read-tag or write-tag FIFO (depth tag_els_p) same edge.
REQ-024 Read channel: when read-tag FIFO non-empty, head id h: dma_data_v_o[h]=mem_data_v_i, mem_data_ready_o=dma_data_ready_i[h], dma_data_o=mem_data_i; all else 0.
REQ-025 Read word counter increments on mem_data_v_i&mem_data_ready_o; at block_size_in_words_p-1 it wraps to 0 and FIFO pops.
REQ-026 Write channel: head id h: mem_data_v_o=dma_data_v_i[h], mem_data_o=dma_data_i[h], dma_data_yumi_o[h]=mem_data_yumi_i; counter/pop as REQ-025.
REQ-027 Read-tag FIFO empty -> mem_data_ready_o=0; write-tag FIFO empty -> mem_data_v_o=0.
REQ-028 Push and pop same cycle on full FIFO SHALL not be permitted (eligibility uses full only); push+pop on non-full FIFO SHALL keep count.
REQ-029 Read and write channels SHALL run concurrently and independently.
REQ-030 Data order per direction SHALL equal packet accept order.

Reset
REQ-031 reset_i SHALL empty both tag FIFOs, zero both word counters, set round-robin pointer to requester 0.
REQ-032 During and after reset all valid/yumi/ready outputs SHALL be 0 until inputs demand otherwise; reset mid-transfer drops the transfer.

Configuration
REQ-033 Macro BSG_CACHE_DMA_ARB_RR_EN defined: round-robin; pointer advances to grant+1 mod num_req_p on each accept only.
REQ-034 Macro undefined: fixed priority, lowest index wins; no pointer state.

Verification
REQ-035 RR on, num_req_p=4, all four issue reads, mem_pkt_yumi_i=1 -> accept order 0,1,2,3, then 0.
REQ-036 Read from req 2, block 4, mem streams A,B,C,D -> only dma_data_v_o[2] pulses, 4 words, then read FIFO empty.
REQ-037 Write from req 1 then read from req 3 -> mem write data sourced only from req 1 while read data goes to req 3 concurrently.
REQ-038 tag_els_p=2, three reads outstanding -> third pkt not accepted until first block's last word pops.
REQ-039 dma_data_ready_i[h]=0 for 5 cycles mid-block -> mem_data_ready_o=0, counter holds, no data lost.
REQ-040 Reset after word 2 of 4 -> FIFOs empty, counters 0, all handshake outputs 0 next cycle.
